tof_receiver: RTL and testbench

TOF_RECEIVER -- requirements
Module: tof_receiver

---
 rtl/tof_pkg.sv | 29 ++
 rtl/tof_sync.sv | 34 +++
 rtl/tof_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_tof_receiver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_pkg.sv
// Shared definitions for the time-of-flight receiver: register map, FSM state
// codes, CTRL/STATUS bit positions and the default counter width.
package tof_pkg;

    localparam int unsigned TOF_CNT_W_DEFAULT = 16;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_RESULT  = 3'd2;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd3;
    localparam logic [2:0] ADDR_BLANK   = 3'd4;
    localparam logic [2:0] ADDR_SHOTS   = 3'd5;

    typedef logic [1:0] tof_state_t;
    localparam tof_state_t ST_IDLE      = 2'd0;
    localparam tof_state_t ST_BLANK     = 2'd1;
    localparam tof_state_t ST_WAIT_STOP = 2'd2;
    localparam tof_state_t ST_DONE      = 2'd3;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_CLR      = 1;
    localparam int unsigned CTRL_IRQ_MASK = 2;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_VALID    = 1;
    localparam int unsigned STAT_TIMEOUT  = 2;
    localparam int unsigned STAT_OVERRUN  = 3;

endpackage

// File: rtl/tof_sync.sv
// Multi-flop synchronizer for one asynchronous input, followed by a
// single-cycle rising-edge pulse.
module tof_sync
    import tof_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tof_receiver.sv
// Time-of-flight receiver with Avalon-MM register interface.
// Optional interrupt output is built only when TOF_IRQ_EN is defined.
module tof_receiver
    import tof_pkg::*;
#(
    parameter int unsigned CNT_W       = TOF_CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        avmms_clk,
    input  logic        avmms_reset,
    input  logic        laser_en,
    input  logic        comparator,
    input  logic        avmms_cs,
    input  logic [2:0]  avmms_address,
    input  logic        avmms_write,
    input  logic [31:0] avmms_writedata,
    input  logic        avmms_read,
    output logic [31:0] avmms_readdata
`ifdef TOF_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic laser_rise, echo_rise;

    tof_sync #(.STAGES(SYNC_STAGES)) u_sync_laser (
        .clk      (avmms_clk),
        .rst_n    (avmms_reset),
        .async_in (laser_en),
        .rise     (laser_rise)
    );

    tof_sync #(.STAGES(SYNC_STAGES)) u_sync_echo (
        .clk      (avmms_clk),
        .rst_n    (avmms_reset),
        .async_in (comparator),
        .rise     (echo_rise)
    );

    tof_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             meas_to_q, meas_to_d;
    logic             enable_q, enable_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic [CNT_W-1:0] blank_q, blank_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             to_flag_q, to_flag_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      shots_q, shots_d;
    logic [31:0]      rdata_q, rdata_d;
`ifdef TOF_IRQ_EN
    logic             mask_q, mask_d;
    logic             irq_q, irq_d;
`endif

    logic             wr, rd, wr_ctrl, en_next, busy, mask_bit;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_wdata;

    assign unused_wdata = ^avmms_writedata;
    assign wr      = avmms_cs & avmms_write;
    assign rd      = avmms_cs & avmms_read;
    assign wr_ctrl = wr && (avmms_address == ADDR_CTRL);
    assign busy    = (state_q == ST_BLANK) || (state_q == ST_WAIT_STOP);
`ifdef TOF_IRQ_EN
    assign mask_bit = mask_q;
    assign irq      = irq_q;
`else
    assign mask_bit = 1'b0;
`endif

    // Counter value as it will stand after this edge, i.e. elapsed cycles
    // since the start pulse was seen.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign en_next = wr_ctrl ? avmms_writedata[CTRL_EN] : enable_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        meas_d    = meas_q;
        meas_to_d = meas_to_q;
        enable_d  = enable_q;
        timeout_d = timeout_q;
        blank_d   = blank_q;
        result_d  = result_q;
        valid_d   = valid_q;
        to_flag_d = to_flag_q;
        overrun_d = overrun_q;
        shots_d   = shots_q;
        rdata_d   = '0;
`ifdef TOF_IRQ_EN
        mask_d    = mask_q;
        irq_d     = valid_q & mask_q;
`endif

        if (rd && avmms_address == ADDR_RESULT) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_q && laser_rise) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= blank_q) begin
                    if (blank_q >= timeout_q) begin
                        state_d   = ST_DONE;
                        meas_d    = timeout_q;
                        meas_to_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_STOP;
                    end
                end
            end
            ST_WAIT_STOP: begin
                cnt_d = cnt_inc;
                if (echo_rise) begin
                    state_d   = ST_DONE;
                    meas_d    = cnt_inc;
                    meas_to_d = 1'b0;
                end else if (cnt_inc >= timeout_q) begin
                    state_d   = ST_DONE;
                    meas_d    = timeout_q;
                    meas_to_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                result_d  = meas_q;
                valid_d   = 1'b1;
                overrun_d = overrun_q | valid_q;
                to_flag_d = to_flag_q | meas_to_q;
                shots_d   = shots_q + 16'd1;
            end
        endcase

        if (!en_next && busy) begin
            state_d = ST_IDLE;
        end

        if (wr) begin
            case (avmms_address)
                ADDR_CTRL: begin
                    enable_d = avmms_writedata[CTRL_EN];
`ifdef TOF_IRQ_EN
                    mask_d   = avmms_writedata[CTRL_IRQ_MASK];
`endif
                    if (avmms_writedata[CTRL_CLR]) begin
                        valid_d   = 1'b0;
                        to_flag_d = 1'b0;
                        overrun_d = 1'b0;
                        shots_d   = '0;
                    end
                end
                ADDR_TIMEOUT: timeout_d = avmms_writedata[CNT_W-1:0];
                ADDR_BLANK:   blank_d   = avmms_writedata[CNT_W-1:0];
                default: ;
            endcase
        end

        if (rd) begin
            case (avmms_address)
                ADDR_CTRL:    rdata_d = 32'({mask_bit, 1'b0, enable_q});
                ADDR_STATUS:  rdata_d = 32'({overrun_q, to_flag_q, valid_q, busy});
                ADDR_RESULT:  rdata_d = 32'(result_q);
                ADDR_TIMEOUT: rdata_d = 32'(timeout_q);
                ADDR_BLANK:   rdata_d = 32'(blank_q);
                ADDR_SHOTS:   rdata_d = 32'(shots_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge avmms_clk or negedge avmms_reset) begin
        if (!avmms_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            meas_q    <= '0;
            meas_to_q <= 1'b0;
            enable_q  <= 1'b0;
            timeout_q <= '1;
            blank_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            to_flag_q <= 1'b0;
            overrun_q <= 1'b0;
            shots_q   <= '0;
            rdata_q   <= '0;
`ifdef TOF_IRQ_EN
            mask_q    <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            meas_q    <= meas_d;
            meas_to_q <= meas_to_d;
            enable_q  <= enable_d;
            timeout_q <= timeout_d;
            blank_q   <= blank_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            to_flag_q <= to_flag_d;
            overrun_q <= overrun_d;
            shots_q   <= shots_d;
            rdata_q   <= rdata_d;
`ifdef TOF_IRQ_EN
            mask_q    <= mask_d;
            irq_q     <= irq_d;
`endif
        end
    end

    assign avmms_readdata = rdata_q;

endmodule

// File: tb/tb_tof_receiver.sv
// Self-checking bench for tof_receiver: register-level model of measurement
// outcomes plus directed shots with hand-computed results.
module tb_tof_receiver;
    import tof_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        laser_en = 1'b0;
    logic        comparator = 1'b0;
    logic        avmms_cs = 1'b0;
    logic [2:0]  avmms_address = '0;
    logic        avmms_write = 1'b0;
    logic [31:0] avmms_writedata = '0;
    logic        avmms_read = 1'b0;
    logic [31:0] avmms_readdata;
`ifdef TOF_IRQ_EN
    logic        irq;
`endif

    tof_receiver #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .avmms_clk       (clk),
        .avmms_reset     (rst_n),
        .laser_en        (laser_en),
        .comparator      (comparator),
        .avmms_cs        (avmms_cs),
        .avmms_address   (avmms_address),
        .avmms_write     (avmms_write),
        .avmms_writedata (avmms_writedata),
        .avmms_read      (avmms_read),
        .avmms_readdata  (avmms_readdata)
`ifdef TOF_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Register-level model of what the block should report
    logic [31:0] m_ctrl = '0;
    logic        m_busy = 1'b0, m_valid = 1'b0, m_to = 1'b0, m_overrun = 1'b0;
    logic [15:0] m_result = '0, m_tmo = 16'hFFFF, m_blank = '0, m_shots = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            ADDR_CTRL:    return m_ctrl;
            ADDR_STATUS:  return {28'd0, m_overrun, m_to, m_valid, m_busy};
            ADDR_RESULT:  return {16'd0, m_result};
            ADDR_TIMEOUT: return {16'd0, m_tmo};
            ADDR_BLANK:   return {16'd0, m_blank};
            ADDR_SHOTS:   return {16'd0, m_shots};
            default:      return 32'd0;
        endcase
    endfunction

    // Compare process: every read data beat is checked against the model
    bit          rd_pend = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [2:0]  rd_addr_s = '0;
    always @(posedge clk) begin
        rd_pend   <= rst_n && avmms_cs && avmms_read;
        exp_rd    <= model_read(avmms_address);
        rd_addr_s <= avmms_address;
    end
    always @(negedge clk) begin
        if (rd_pend) check($sformatf("model_rd_addr%0d", rd_addr_s), avmms_readdata, exp_rd);
    end

    task automatic model_reset();
        m_ctrl = '0; m_busy = 0; m_valid = 0; m_to = 0; m_overrun = 0;
        m_result = '0; m_tmo = 16'hFFFF; m_blank = '0; m_shots = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avmms_cs = 1; avmms_write = 1; avmms_address = a; avmms_writedata = d;
        @(posedge clk); #1;
        avmms_cs = 0; avmms_write = 0;
        if (a == ADDR_CTRL) begin
`ifdef TOF_IRQ_EN
            m_ctrl = {29'd0, d[2], 1'b0, d[0]};
`else
            m_ctrl = {31'd0, d[0]};
`endif
            if (!d[0]) m_busy = 0;
            if (d[1]) begin m_valid = 0; m_to = 0; m_overrun = 0; m_shots = '0; end
        end else if (a == ADDR_TIMEOUT) m_tmo = d[15:0];
        else if (a == ADDR_BLANK) m_blank = d[15:0];
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avmms_cs = 1; avmms_read = 1; avmms_address = a;
        @(posedge clk); #1;
        avmms_cs = 0; avmms_read = 0;
        if (a == ADDR_RESULT) m_valid = 0;
        @(negedge clk);
        d = avmms_readdata;
    endtask

    task automatic rd_lit(input string nm, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(nm, d, exp);
    endtask

    // Outcome of one shot from the timing rules: the blanking window covers
    // elapsed cycles 1..max(BLANK,1); the first later echo at or before
    // TIMEOUT is the result, otherwise the result is TIMEOUT with a timeout.
    task automatic model_shot(input int e1, input int e2, output int res, output bit tmo, output int fin);
        int b, t, l;
        b = int'(m_blank); t = int'(m_tmo);
        l = (b > 1) ? b : 1;
        if (b >= t) begin res = t; tmo = 1; fin = l; end
        else if (e1 > l && e1 <= t) begin res = e1; tmo = 0; fin = e1; end
        else if (e2 > l && e2 <= t) begin res = e2; tmo = 0; fin = e2; end
        else begin res = t; tmo = 1; fin = t; end
    endtask

    task automatic shot(input int e1, input int e2);
        int res, fin; bit tmo;
        model_shot(e1, e2, res, tmo, fin);
        for (int c = 0; c < fin + 12; c++) begin
            laser_en   = (c < 3);
            comparator = (e1 >= 0 && c >= e1 && c < e1 + 2) || (e2 >= 0 && c >= e2 && c < e2 + 2);
            @(posedge clk); #1;
        end
        laser_en = 0; comparator = 0;
        if (m_valid) m_overrun = 1;
        m_valid = 1; m_result = 16'(res); m_shots = m_shots + 16'd1;
        if (tmo) m_to = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", avmms_readdata, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;
        rd_lit("reset_ctrl", ADDR_CTRL, 32'd0);
        rd_lit("reset_status", ADDR_STATUS, 32'd0);
        rd_lit("reset_result", ADDR_RESULT, 32'd0);
        rd_lit("reset_timeout", ADDR_TIMEOUT, 32'h0000FFFF);
        rd_lit("reset_blank", ADDR_BLANK, 32'd0);
        rd_lit("reset_shots", ADDR_SHOTS, 32'd0);

        wr(ADDR_TIMEOUT, 1000); wr(ADDR_BLANK, 0); wr(ADDR_CTRL, 1);
        wr(ADDR_RESULT, 32'h1234); wr(3'd7, 32'hFFFF);
        rd_lit("timeout_rw", ADDR_TIMEOUT, 32'd1000);
        rd_lit("ctrl_rw", ADDR_CTRL, 32'd1);
        rd_lit("result_ro", ADDR_RESULT, 32'd0);
        rd_lit("unused_addr", 3'd7, 32'd0);

        shot(13, -1);
        rd_lit("basic_status", ADDR_STATUS, 32'd2);
        rd_lit("basic_shots", ADDR_SHOTS, 32'd1);
        rd_lit("basic_result", ADDR_RESULT, 32'd13);
        rd_lit("read_clears_valid", ADDR_STATUS, 32'd0);

        wr(ADDR_BLANK, 20);
        shot(10, 30);
        rd_lit("blank_result", ADDR_RESULT, 32'd30);

        wr(ADDR_BLANK, 0); wr(ADDR_TIMEOUT, 50);
        shot(-1, -1);
        rd_lit("timeout_status", ADDR_STATUS, 32'd6);
        rd_lit("timeout_result", ADDR_RESULT, 32'd50);

        wr(ADDR_CTRL, 3);
        rd_lit("clear_status", ADDR_STATUS, 32'd0);
        rd_lit("clear_shots", ADDR_SHOTS, 32'd0);
        rd_lit("clear_keeps_en", ADDR_CTRL, 32'd1);

        wr(ADDR_TIMEOUT, 40);
        shot(40, -1);
        rd_lit("tie_status", ADDR_STATUS, 32'd2);
        rd_lit("tie_result", ADDR_RESULT, 32'd40);

        wr(ADDR_BLANK, 60); wr(ADDR_TIMEOUT, 50);
        shot(-1, -1);
        rd_lit("blank_ge_to_status", ADDR_STATUS, 32'd6);
        rd_lit("blank_ge_to_result", ADDR_RESULT, 32'd50);

        wr(ADDR_BLANK, 0); wr(ADDR_TIMEOUT, 1000); wr(ADDR_CTRL, 3);
        shot(20, -1);
        shot(25, -1);
        rd_lit("overrun_status", ADDR_STATUS, 32'd10);
        rd_lit("overrun_result", ADDR_RESULT, 32'd25);
        rd_lit("overrun_after_read", ADDR_STATUS, 32'd8);
        rd_lit("overrun_shots", ADDR_SHOTS, 32'd2);

        // Abort a shot by dropping enable while waiting for the echo
        laser_en = 1;
        repeat (3) begin @(posedge clk); #1; end
        laser_en = 0;
        repeat (5) begin @(posedge clk); #1; end
        m_busy = 1;
        rd_lit("abort_busy", ADDR_STATUS, 32'd9);
        wr(ADDR_CTRL, 0);
        repeat (2) begin @(posedge clk); #1; end
        comparator = 1;
        repeat (2) begin @(posedge clk); #1; end
        comparator = 0;
        repeat (8) begin @(posedge clk); #1; end
        rd_lit("abort_status", ADDR_STATUS, 32'd8);
        rd_lit("abort_shots", ADDR_SHOTS, 32'd2);

`ifdef TOF_IRQ_EN
        wr(ADDR_CTRL, 5);
        rd_lit("ctrl_mask_rw", ADDR_CTRL, 32'd5);
        shot(15, -1);
        check("irq_set", {31'd0, irq}, 32'd1);
        rd_lit("irq_result", ADDR_RESULT, 32'd15);
        repeat (3) begin @(posedge clk); #1; end
        check("irq_cleared", {31'd0, irq}, 32'd0);
        wr(ADDR_CTRL, 1);
        shot(15, -1);
        check("irq_masked", {31'd0, irq}, 32'd0);
        rd_lit("masked_result", ADDR_RESULT, 32'd15);
`else
        wr(ADDR_CTRL, 5);
        rd_lit("ctrl_mask_absent", ADDR_CTRL, 32'd1);
        wr(ADDR_CTRL, 1);
`endif

        // Reset in the middle of a shot
        wr(ADDR_TIMEOUT, 300); wr(ADDR_BLANK, 7);
        laser_en = 1;
        repeat (3) begin @(posedge clk); #1; end
        laser_en = 0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 0;
        model_reset();
        repeat (2) begin @(posedge clk); #1; end
        check("midshot_reset_rdata", avmms_readdata, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;
        rd_lit("post_reset_status", ADDR_STATUS, 32'd0);
        rd_lit("post_reset_timeout", ADDR_TIMEOUT, 32'h0000FFFF);
        rd_lit("post_reset_blank", ADDR_BLANK, 32'd0);
        rd_lit("post_reset_ctrl", ADDR_CTRL, 32'd0);
        rd_lit("post_reset_shots", ADDR_SHOTS, 32'd0);
        rd_lit("post_reset_result", ADDR_RESULT, 32'd0);
        rd(ADDR_CTRL, d);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
